// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit owning the architectural HI/LO
// registers. MULT/MULTU use shift-add over WIDTH cycles. DIV/DIVU use
// restoring division over WIDTH cycles. A final FIX cycle applies sign
// correction and writes HI/LO.
// Optional feature macro: MULDIV_DIV_EN. When it is defined, DIV/DIVU are
// supported. When it is undefined, the divider is compiled out and divide
// starts are ignored.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             hiwe,
    input  logic             lowe,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

`ifdef MULDIV_DIV_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIX  = 2'd3
    } state_t;
`endif

    state_t state;
    state_t state_next;

    // control decode
    logic accept;
    logic mt_ok;
    logic last;

    // operand preparation
    logic             signed_op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;

    // shared iteration state
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_mag;
    logic               neg_res;
    logic [2*WIDTH-1:0] prod;

    // multiplier step / fix-up
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] prod_fix;

    // architectural registers
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

`ifdef MULDIV_DIV_EN
    // divider state
    logic             is_div;
    logic             neg_rem;
    logic             div_zero;
    logic [WIDTH-1:0] a_orig;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;

    // divider step / fix-up
    logic [WIDTH+1:0] div_diff;
    logic [WIDTH:0]   div_keep;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: accept starts, gate MTHI/MTLO, count iterations
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        mt_ok      = 1'b0;
        last       = (cnt == CNT_W'(WIDTH - 1));
        case (state)
            IDLE: begin
                if (start) begin
                    if (!op[1]) begin
                        accept     = 1'b1;
                        state_next = MUL;
                    end
`ifdef MULDIV_DIV_EN
                    else begin
                        accept     = 1'b1;
                        state_next = DIV;
                    end
`endif
                end else begin
                    mt_ok = 1'b1;
                end
            end
            MUL: begin
                if (last) begin
                    state_next = FIX;
                end
            end
`ifdef MULDIV_DIV_EN
            DIV: begin
                if (last) begin
                    state_next = FIX;
                end
            end
`endif
            FIX: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand magnitudes: signed ops work on absolute values plus sign flags
    always_comb begin
        signed_op = ~op[0];
        a_in      = (signed_op && srca[WIDTH-1]) ? -srca : srca;
        b_in      = (signed_op && srcb[WIDTH-1]) ? -srcb : srcb;
    end

    // Shift-add step: the multiplier sits in the low half and shifts out as
    // the partial product grows into the upper half
    always_comb begin
        mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, a_mag};
        mul_next = prod[0] ? {mul_sum, prod[WIDTH-1:1]}
                           : {1'b0, prod[2*WIDTH-1:1]};
    end

`ifdef MULDIV_DIV_EN
    // Restoring step: try subtracting the divisor from the shifted remainder
    // and keep the shifted value when the trial goes negative
    always_comb begin
        div_diff = {rem, quo[WIDTH-1]} - {2'b00, b_mag};
        div_keep = {rem[WIDTH-1:0], quo[WIDTH-1]};
        rem_next = div_diff[WIDTH+1] ? div_keep : div_diff[WIDTH:0];
        quo_next = {quo[WIDTH-2:0], ~div_diff[WIDTH+1]};
    end
`endif

    // Final result: sign correction, then the HI/LO mapping per operation
    always_comb begin
        prod_fix = neg_res ? -prod : prod;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        quo_fix  = neg_res ? -quo : quo;
        rem_fix  = neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
        if (is_div) begin
            // Divide by zero returns the untouched dividend and an all-ones
            // quotient, independent of signedness
            if (div_zero) begin
                res_hi = a_orig;
                res_lo = '1;
            end else begin
                res_hi = rem_fix;
                res_lo = quo_fix;
            end
        end
`endif
    end

    // Datapath registers: operand latch, iteration, HI/LO writes, done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            a_mag    <= '0;
            neg_res  <= 1'b0;
            prod     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div   <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            a_orig   <= '0;
            b_mag    <= '0;
            rem      <= '0;
            quo      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt      <= '0;
                        a_mag    <= a_in;
                        neg_res  <= signed_op & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                        prod     <= {{WIDTH{1'b0}}, b_in};
`ifdef MULDIV_DIV_EN
                        is_div   <= op[1];
                        neg_rem  <= signed_op & srca[WIDTH-1];
                        div_zero <= (srcb == '0);
                        a_orig   <= srca;
                        b_mag    <= b_in;
                        rem      <= '0;
                        quo      <= a_in;
`endif
                    end else if (mt_ok) begin
                        if (hiwe) begin
                            hi_q <= srca;
                        end
                        if (lowe) begin
                            lo_q <= srca;
                        end
                    end
                end
                MUL: begin
                    prod <= mul_next;
                    cnt  <= cnt + CNT_W'(1);
                end
`ifdef MULDIV_DIV_EN
                DIV: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + CNT_W'(1);
                end
`endif
                FIX: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed bench for muldiv_unit (WIDTH=32). Expected HI/LO
// pairs are queued when an operation is launched and popped on done.
// Divider checks are built only when MULDIV_DIV_EN is defined; otherwise the
// bench checks that divide starts are ignored.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] srca;
    logic [W-1:0] srcb;
    logic         hiwe;
    logic         lowe;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    logic [2*W-1:0] scb[$];

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .srca  (srca),
        .srcb  (srcb),
        .hiwe  (hiwe),
        .lowe  (lowe),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    function automatic logic [63:0] model_mul(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa;
        longint sb;
        if (o[0]) return {32'h0, a} * {32'h0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    function automatic logic [63:0] model_div(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (o[0]) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {32'(r), 32'(q)};
    endfunction

    // Drive a start for one cycle from a negedge; returns at the next negedge.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] want);
        start = 1'b1;
        op    = o;
        srca  = a;
        srcb  = b;
        scb.push_back(want);
        @(negedge clk);
        start = 1'b0;
        srca  = ~a;
        srcb  = ~b;
        check("done_low_after_start", {63'h0, done}, 64'h1 & 64'h0 | {63'h0, 1'b0});
    endtask

    // Count busy cycles until done, bounded, then compare against the queue.
    task automatic wait_done(input string tag, input int busy_want);
        int n;
        int guard;
        logic [63:0] want;
        n     = 0;
        guard = 0;
        while (done !== 1'b1 && guard < 200) begin
            if (busy === 1'b1) n++;
            @(negedge clk);
            guard++;
        end
        check({tag, "_done"}, {63'h0, done}, 64'h1);
        check({tag, "_busy_cycles"}, 64'(n), 64'(busy_want));
        check({tag, "_busy_low"}, {63'h0, busy}, 64'h0);
        want = (scb.size() != 0) ? scb.pop_front() : 64'hx;
        check({tag, "_hilo"}, {hi, lo}, want);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  ro;
        bit          seen_busy;
        bit          seen_done;

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        srca  = '0;
        srcb  = '0;
        hiwe  = 1'b0;
        lowe  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_hi", {32'h0, hi}, 64'h0);
        check("reset_lo", {32'h0, lo}, 64'h0);
        check("reset_busy", {63'h0, busy}, 64'h0);
        check("reset_done", {63'h0, done}, 64'h0);
        reset = 1'b0;
        @(negedge clk);

        // Largest unsigned product
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        wait_done("multu_max", 33);
        @(negedge clk);
        check("multu_max_done_pulse", {63'h0, done}, 64'h0);
        check("multu_max_hold", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        // Signed multiply, then back-to-back issue on the done cycle
        launch(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB);
        wait_done("mult_neg", 33);
        launch(2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        wait_done("mult_min_sq", 33);

        // Random multiplies against a 64-bit arithmetic model
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            ro = {1'b0, i[0]};
            launch(ro, ra, rb, model_mul(ro, ra, rb));
            wait_done("mul_rand", 33);
        end
        @(negedge clk);

        // MTHI / MTLO in idle
        hiwe = 1'b1;
        srca = 32'hAAAA_5555;
        @(negedge clk);
        hiwe = 1'b0;
        check("mthi", {32'h0, hi}, 64'hAAAA_5555);
        lowe = 1'b1;
        srca = 32'h1234_5678;
        @(negedge clk);
        lowe = 1'b0;
        check("mtlo", {32'h0, lo}, 64'h1234_5678);
        check("mtlo_hi_hold", {32'h0, hi}, 64'hAAAA_5555);
        hiwe = 1'b1;
        lowe = 1'b1;
        srca = 32'h0F0F_F0F0;
        @(negedge clk);
        hiwe = 1'b0;
        lowe = 1'b0;
        check("mt_both", {hi, lo}, 64'h0F0F_F0F0_0F0F_F0F0);

        // hiwe/lowe alongside an accepted start are ignored
        hiwe = 1'b1;
        lowe = 1'b1;
        launch(2'b01, 32'd5, 32'd6, 64'd30);
        hiwe = 1'b0;
        lowe = 1'b0;
        check("mt_with_start", {hi, lo}, 64'h0F0F_F0F0_0F0F_F0F0);
        repeat (4) @(negedge clk);
        // start/hiwe/lowe pulsed while busy are ignored
        hiwe  = 1'b1;
        lowe  = 1'b1;
        start = 1'b1;
        op    = 2'b00;
        srca  = 32'hDEAD_BEEF;
        srcb  = 32'd3;
        @(negedge clk);
        hiwe  = 1'b0;
        lowe  = 1'b0;
        start = 1'b0;
        check("mt_while_busy", {hi, lo}, 64'h0F0F_F0F0_0F0F_F0F0);
        wait_done("ignore_while_busy", 28);
        @(negedge clk);

        // Reset during a multiply aborts it
        launch(2'b00, 32'h0001_2345, 32'h0000_0777, 64'h0);
        repeat (8) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_hi", {32'h0, hi}, 64'h0);
        check("abort_lo", {32'h0, lo}, 64'h0);
        check("abort_busy", {63'h0, busy}, 64'h0);
        check("abort_done", {63'h0, done}, 64'h0);
        scb.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        launch(2'b01, 32'd7, 32'd9, 64'd63);
        wait_done("after_abort", 33);
        @(negedge clk);

`ifdef MULDIV_DIV_EN
        launch(2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        wait_done("div_neg", 33);
        launch(2'b11, 32'd100, 32'd7, {32'd2, 32'd14});
        wait_done("divu", 33);
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        wait_done("div_ovf", 33);
        launch(2'b11, 32'h0000_1234, 32'h0, 64'h0000_1234_FFFF_FFFF);
        wait_done("divu_zero", 33);
        launch(2'b10, 32'hFFFF_FFFB, 32'h0, 64'hFFFF_FFFB_FFFF_FFFF);
        wait_done("div_zero", 33);
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom >> (i * 5);
            ro = {1'b1, i[0]};
            launch(ro, ra, rb, model_div(ro, ra, rb));
            wait_done("div_rand", 33);
        end
`else
        // Divide starts are dropped; HI/LO keep the 7*9 result
        start = 1'b1;
        op    = 2'b11;
        srca  = 32'h0000_1234;
        srcb  = 32'h0;
        @(negedge clk);
        start     = 1'b0;
        seen_busy = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            if (busy !== 1'b0) seen_busy = 1'b1;
            if (done !== 1'b0) seen_done = 1'b1;
            @(negedge clk);
        end
        check("nodiv_busy", {63'h0, seen_busy}, 64'h0);
        check("nodiv_done", {63'h0, seen_done}, 64'h0);
        check("nodiv_hilo", {hi, lo}, 64'd63);
        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
        wait_done("nodiv_mult_after", 33);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
